// File: rtl/cart_sdram_arbiter.sv
// Arbitrates the byte-wide SDRAM port between the HPS download writer and the cart fetcher,
// with one pending slot per requester and a one-entry read cache for cart fetches.
module cart_sdram_arbiter #(
    parameter int                ADDR_W    = 25,
    parameter int                CART_AW   = 20,
    parameter logic [ADDR_W-1:0] CART_BASE = '0,
    parameter int                TIMEOUT   = 64
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               dl_wr,
    input  logic [ADDR_W-1:0]  dl_addr,
    input  logic [7:0]         dl_data,
    output logic               dl_busy,
    input  logic               cart_rd,
    input  logic [CART_AW-1:0] cart_a,
    output logic [7:0]         cart_d,
    output logic               cart_valid,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [7:0]         mem_din,
    output logic               mem_rd,
    output logic               mem_we,
    input  logic [7:0]         mem_dout,
    input  logic               mem_done,
    output logic               overrun,
    output logic               timeout_err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_WR, WAIT_RD} state_t;

    state_t               state_q, state_d;
    logic                 wpend_q, wpend_d, w_newer_q, w_newer_d;
    logic [ADDR_W-1:0]    waddr_q, waddr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic                 rpend_q, rpend_d, r_newer_q, r_newer_d;
    logic [CART_AW-1:0]   raddr_q, raddr_d, rd_tag_q, rd_tag_d;
    logic                 cache_valid_q, cache_valid_d;
    logic [CART_AW-1:0]   cache_tag_q, cache_tag_d;
    logic [7:0]           cache_data_q, cache_data_d;
    logic [7:0]           cart_d_q, cart_d_d;
    logic                 cart_valid_q, cart_valid_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [7:0]           mem_din_q, mem_din_d;
    logic                 mem_rd_q, mem_rd_d, mem_we_q, mem_we_d;
    logic                 overrun_q, overrun_d, timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 cache_hit, rd_miss, timed_out;

    function automatic logic [ADDR_W-1:0] map_addr(input logic [CART_AW-1:0] a);
        return CART_BASE + ADDR_W'(a);
    endfunction

    // A held write to the same byte would make the cached copy stale.
    assign cache_hit = cache_valid_q && (cache_tag_q == cart_a) && !dl_wr &&
                       !(wpend_q && (waddr_q == map_addr(cart_a)));
    assign rd_miss   = cart_rd && !cache_hit;
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        wpend_d       = wpend_q;
        w_newer_d     = w_newer_q;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        rpend_d       = rpend_q;
        r_newer_d     = r_newer_q;
        raddr_d       = raddr_q;
        rd_tag_d      = rd_tag_q;
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
        cart_d_d      = cart_d_q;
        cart_valid_d  = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        mem_rd_d      = 1'b0;
        mem_we_d      = 1'b0;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;

        if (dl_wr) begin
            wpend_d   = 1'b1;
            w_newer_d = 1'b1;
            waddr_d   = dl_addr;
            wdata_d   = dl_data;
            if (wpend_q) overrun_d = 1'b1;
        end
        if (rd_miss) begin
            rpend_d   = 1'b1;
            r_newer_d = 1'b1;
            raddr_d   = cart_a;
        end
        if (cart_rd && cache_hit) begin
            cart_d_d     = cache_data_q;
            cart_valid_d = 1'b1;
        end

        // The newer flags keep a request that arrived during an access alive past its completion.
        case (state_q)
            IDLE: begin
                if (wpend_q || dl_wr) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = dl_wr ? dl_addr : waddr_q;
                    mem_din_d  = dl_wr ? dl_data : wdata_q;
                    w_newer_d  = 1'b0;
                    cnt_d      = '0;
                    state_d    = WAIT_WR;
                end else if (rpend_q || rd_miss) begin
                    mem_rd_d   = 1'b1;
                    rd_tag_d   = rd_miss ? cart_a : raddr_q;
                    mem_addr_d = map_addr(rd_miss ? cart_a : raddr_q);
                    r_newer_d  = 1'b0;
                    cnt_d      = '0;
                    state_d    = WAIT_RD;
                end
            end
            WAIT_WR: begin
                if (mem_done || timed_out) begin
                    wpend_d = w_newer_q || dl_wr;
                    if (mem_done && cache_valid_q && (mem_addr_q == map_addr(cache_tag_q)))
                        cache_valid_d = 1'b0;
                    if (!mem_done) timeout_err_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_RD: begin
                if (mem_done) begin
                    cart_d_d      = mem_dout;
                    cart_valid_d  = 1'b1;
                    cache_valid_d = 1'b1;
                    cache_tag_d   = rd_tag_q;
                    cache_data_d  = mem_dout;
                end else if (timed_out) begin
                    cart_d_d      = 8'hFF;
                    cart_valid_d  = 1'b1;
                    cache_valid_d = 1'b0;
                    timeout_err_d = 1'b1;
                end
                if (mem_done || timed_out) begin
                    rpend_d = r_newer_q || rd_miss;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (dl_wr) cache_valid_d = 1'b0;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= IDLE;
            wpend_q       <= 1'b0;
            w_newer_q     <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            rpend_q       <= 1'b0;
            r_newer_q     <= 1'b0;
            raddr_q       <= '0;
            rd_tag_q      <= '0;
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= '0;
            cart_d_q      <= 8'hFF;
            cart_valid_q  <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_rd_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            wpend_q       <= wpend_d;
            w_newer_q     <= w_newer_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            rpend_q       <= rpend_d;
            r_newer_q     <= r_newer_d;
            raddr_q       <= raddr_d;
            rd_tag_q      <= rd_tag_d;
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_data_q  <= cache_data_d;
            cart_d_q      <= cart_d_d;
            cart_valid_q  <= cart_valid_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            mem_rd_q      <= mem_rd_d;
            mem_we_q      <= mem_we_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign dl_busy     = wpend_q || (state_q == WAIT_WR);
    assign cart_d      = cart_d_q;
    assign cart_valid  = cart_valid_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign mem_rd      = mem_rd_q;
    assign mem_we      = mem_we_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_cart_sdram_arbiter.sv
// Self-checking bench for cart_sdram_arbiter: directed scenarios plus a randomized
// download/fetch mix checked against a memory-and-cache reference model.
module tb_cart_sdram_arbiter;
    localparam int          ADDR_W    = 25;
    localparam int          CART_AW   = 20;
    localparam logic [24:0] CART_BASE = 25'h1FF_FF00;
    localparam int          TIMEOUT   = 16;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        dl_wr   = 1'b0;
    logic [24:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        cart_rd = 1'b0;
    logic [19:0] cart_a  = '0;
    logic        dl_busy, cart_valid, mem_rd, mem_we, overrun, timeout_err;
    logic [7:0]  cart_d, mem_din;
    logic [24:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_done;

    int n_checks = 0;
    int n_fail   = 0;

    cart_sdram_arbiter #(
        .ADDR_W(ADDR_W), .CART_AW(CART_AW), .CART_BASE(CART_BASE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_busy(dl_busy),
        .cart_rd(cart_rd), .cart_a(cart_a), .cart_d(cart_d), .cart_valid(cart_valid),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_we(mem_we),
        .mem_dout(mem_dout), .mem_done(mem_done),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // SDRAM controller stand-in: answers each command after resp_lat cycles unless disabled.
    bit [7:0] sdram [bit [24:0]];
    int resp_lat = 3;
    bit resp_en  = 1'b1;
    int wr_count = 0, rd_count = 0, rd_cyc = 0, wr_done_cyc = 0;
    int stray_req = 0, stray_ack = 0;

    initial begin : responder
        int          countdown;
        bit          is_read;
        logic [24:0] rd_addr;
        countdown = 0; is_read = 1'b0; rd_addr = '0;
        mem_done = 1'b0; mem_dout = 8'h00;
        forever begin
            @(negedge clk_sys);
            mem_done = 1'b0;
            if (reset) countdown = 0;
            else if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    mem_done = 1'b1;
                    if (is_read) mem_dout = sdram.exists(rd_addr) ? sdram[rd_addr] : 8'h00;
                    else wr_done_cyc = cyc;
                end
            end
            if (stray_req != stray_ack) begin
                stray_ack = stray_req;
                mem_done  = 1'b1;
                mem_dout  = 8'hA5;
            end
            if (!reset && mem_we) begin
                sdram[mem_addr] = mem_din;
                wr_count++;
                is_read = 1'b0;
                if (resp_en) countdown = resp_lat;
            end
            if (!reset && mem_rd) begin
                rd_count++;
                rd_cyc  = cyc;
                rd_addr = mem_addr;
                is_read = 1'b1;
                if (resp_en) countdown = resp_lat;
            end
        end
    end

    function automatic logic [24:0] map(input int unsigned a);
        logic [31:0] s;
        s = 32'(CART_BASE) + 32'(a);
        return s[24:0];
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic pulse_dl(input logic [24:0] a, input logic [7:0] d);
        dl_wr = 1'b1; dl_addr = a; dl_data = d;
        step();
        dl_wr = 1'b0;
    endtask

    task automatic pulse_rd(input logic [19:0] a);
        cart_rd = 1'b1; cart_a = a;
        step();
        cart_rd = 1'b0;
    endtask

    task automatic wait_not_busy(output int cycles);
        cycles = 0;
        while (dl_busy && cycles < 200) begin step(); cycles++; end
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!cart_valid && cycles < 200) begin step(); cycles++; end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        n_checks++; if (cart_d !== 8'hFF) begin n_fail++; $display("[TB] FAIL reset_cart_d: got %h want ff", cart_d); end
        n_checks++; if ({cart_valid, mem_rd, mem_we} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_strobes: got %b want 000", {cart_valid, mem_rd, mem_we}); end
        n_checks++; if ({dl_busy, overrun, timeout_err} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 000", {dl_busy, overrun, timeout_err}); end
        n_checks++; if ({mem_addr, mem_din} !== 33'h0) begin n_fail++; $display("[TB] FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_din); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_write();
        int c;
        resp_lat = 3;
        pulse_dl(25'h00010, 8'h5A);
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_cmd: mem_we got %b want 1", mem_we); end
        n_checks++; if (mem_addr !== 25'h00010 || mem_din !== 8'h5A) begin n_fail++; $display("[TB] FAIL wr_bus: got %h/%h want 00010/5a", mem_addr, mem_din); end
        n_checks++; if (dl_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_busy: got %b want 1", dl_busy); end
        step();
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_one_cycle: mem_we got %b want 0", mem_we); end
        wait_not_busy(c);
        n_checks++; if (c + 2 !== 2 + resp_lat) begin n_fail++; $display("[TB] FAIL wr_busy_fall: got %0d cycles want %0d", c + 2, 2 + resp_lat); end
        step();
        n_checks++; if (sdram[25'h00010] !== 8'h5A) begin n_fail++; $display("[TB] FAIL wr_stored: got %h want 5a", sdram[25'h00010]); end
    endtask

    task automatic test_simultaneous();
        int c;
        resp_lat = 2;
        pulse_dl(map(32'h123), 8'hC3);
        wait_not_busy(c);
        step();
        dl_wr = 1'b1; dl_addr = 25'h00200; dl_data = 8'h77;
        cart_rd = 1'b1; cart_a = 20'h00123;
        step();
        dl_wr = 1'b0; cart_rd = 1'b0;
        n_checks++; if ({mem_we, mem_rd} !== 2'b10 || mem_addr !== 25'h00200) begin n_fail++; $display("[TB] FAIL sim_write_first: we/rd %b addr %h want 10 00200", {mem_we, mem_rd}, mem_addr); end
        c = 0;
        while (!mem_rd && c < 50) begin step(); c++; end
        n_checks++; if (mem_rd !== 1'b1 || mem_addr !== map(32'h123)) begin n_fail++; $display("[TB] FAIL sim_read_issue: rd %b addr %h want 1 %h", mem_rd, mem_addr, map(32'h123)); end
        wait_valid(c);
        n_checks++; if (cart_valid !== 1'b1 || cart_d !== 8'hC3) begin n_fail++; $display("[TB] FAIL sim_read_data: valid %b data %h want 1 c3", cart_valid, cart_d); end
        step();
        n_checks++; if (rd_cyc - wr_done_cyc !== 2) begin n_fail++; $display("[TB] FAIL back_to_back_gap: got %0d want 2", rd_cyc - wr_done_cyc); end
    endtask

    task automatic test_cache_hit();
        int c, rc;
        resp_lat = 2;
        pulse_dl(map(32'h40), 8'h9E);
        wait_not_busy(c);
        pulse_rd(20'h00040);
        wait_valid(c);
        n_checks++; if (cart_d !== 8'h9E || c + 1 !== 2 + resp_lat) begin n_fail++; $display("[TB] FAIL miss_read: data %h lat %0d want 9e %0d", cart_d, c + 1, 2 + resp_lat); end
        step(2);
        rc = rd_count;
        pulse_rd(20'h00040);
        n_checks++; if (cart_valid !== 1'b1 || cart_d !== 8'h9E) begin n_fail++; $display("[TB] FAIL hit_read: valid %b data %h want 1 9e", cart_valid, cart_d); end
        step(3);
        n_checks++; if (rd_count !== rc) begin n_fail++; $display("[TB] FAIL hit_no_sdram: reads %0d want %0d", rd_count, rc); end
    endtask

    task automatic test_cache_invalidate();
        int c, rc;
        pulse_dl(map(32'h40), 8'h11);
        wait_not_busy(c);
        rc = rd_count;
        pulse_rd(20'h00040);
        n_checks++; if (mem_rd !== 1'b1 || cart_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL inval_miss: rd %b valid %b want 1 0", mem_rd, cart_valid); end
        wait_valid(c);
        n_checks++; if (cart_d !== 8'h11) begin n_fail++; $display("[TB] FAIL inval_data: got %h want 11", cart_d); end
        step();
        n_checks++; if (rd_count !== rc + 1) begin n_fail++; $display("[TB] FAIL inval_reads: got %0d want %0d", rd_count, rc + 1); end
    endtask

    task automatic test_timeout();
        int c;
        resp_en = 1'b0;
        pulse_rd(20'h00055);
        wait_valid(c);
        n_checks++; if (c !== TIMEOUT) begin n_fail++; $display("[TB] FAIL to_cycles: got %0d want %0d", c, TIMEOUT); end
        n_checks++; if (cart_d !== 8'hFF || timeout_err !== 1'b1) begin n_fail++; $display("[TB] FAIL to_abort: data %h err %b want ff 1", cart_d, timeout_err); end
        step();
        resp_en = 1'b1;
        pulse_rd(20'h00040);
        n_checks++; if (mem_rd !== 1'b1 || cart_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL to_idle_cache_inval: rd %b valid %b want 1 0", mem_rd, cart_valid); end
        wait_valid(c);
        n_checks++; if (cart_d !== 8'h11) begin n_fail++; $display("[TB] FAIL to_reread: got %h want 11", cart_d); end
        step();
    endtask

    task automatic test_overrun();
        int c, wc;
        resp_lat = 6;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL ovr_clear: got %b want 0", overrun); end
        wc = wr_count;
        pulse_dl(25'h00300, 8'h01);
        pulse_dl(25'h00300, 8'h02);
        pulse_dl(25'h00300, 8'h03);
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL ovr_set: got %b want 1", overrun); end
        wait_not_busy(c);
        step();
        n_checks++; if (c >= 200 || sdram[25'h00300] !== 8'h03) begin n_fail++; $display("[TB] FAIL ovr_last_data: got %h after %0d want 03", sdram[25'h00300], c); end
        n_checks++; if (wr_count - wc !== 2) begin n_fail++; $display("[TB] FAIL ovr_write_count: got %0d want 2", wr_count - wc); end
    endtask

    task automatic test_reset_in_wait();
        bit bad;
        resp_en = 1'b0;
        pulse_rd(20'h00066);
        n_checks++; if (mem_rd !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_wait_issue: got %b want 1", mem_rd); end
        step(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++; if (cart_d !== 8'hFF || {cart_valid, dl_busy, overrun, timeout_err} !== 4'b0000) begin n_fail++; $display("[TB] FAIL rst_wait_outputs: data %h flags %b want ff 0000", cart_d, {cart_valid, dl_busy, overrun, timeout_err}); end
        n_checks++; if (mem_addr !== 25'h0) begin n_fail++; $display("[TB] FAIL rst_wait_addr: got %h want 0", mem_addr); end
        step();
        stray_req++;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (cart_valid || mem_rd || mem_we) bad = 1'b1;
        end
        n_checks++; if (bad !== 1'b0 || cart_d !== 8'hFF) begin n_fail++; $display("[TB] FAIL stray_done: activity %b data %h want 0 ff", bad, cart_d); end
        resp_en = 1'b1;
    endtask

    task automatic test_random();
        bit [7:0]    ref_mem [bit [24:0]];
        bit          cache_ok;
        int unsigned cache_a, a;
        logic [7:0]  d, exp_d;
        int          c;
        cache_ok = 1'b0; cache_a = 0;
        for (int i = 0; i < 40; i++) begin
            a = 32'h80 + $urandom_range(0, 5);
            resp_lat = $urandom_range(1, 5);
            if ($urandom_range(0, 2) == 0) begin
                d = 8'($urandom);
                ref_mem[map(a)] = d;
                cache_ok = 1'b0;
                pulse_dl(map(a), d);
                wait_not_busy(c);
                n_checks++; if (c + 1 !== 2 + resp_lat) begin n_fail++; $display("[TB] FAIL rnd_write_%0d: busy %0d cycles want %0d", i, c + 1, 2 + resp_lat); end
            end else begin
                exp_d = ref_mem.exists(map(a)) ? ref_mem[map(a)] : 8'h00;
                pulse_rd(20'(a));
                if (cache_ok && cache_a == a) begin
                    n_checks++; if (cart_valid !== 1'b1 || cart_d !== exp_d) begin n_fail++; $display("[TB] FAIL rnd_hit_%0d: valid %b data %h want 1 %h", i, cart_valid, cart_d, exp_d); end
                end else begin
                    wait_valid(c);
                    n_checks++; if (c + 1 !== 2 + resp_lat || cart_d !== exp_d) begin n_fail++; $display("[TB] FAIL rnd_miss_%0d: lat %0d data %h want %0d %h", i, c + 1, cart_d, 2 + resp_lat, exp_d); end
                    cache_ok = 1'b1;
                    cache_a  = a;
                end
                step();
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_simultaneous();
        test_cache_hit();
        test_cache_invalidate();
        test_timeout();
        test_overrun();
        test_reset_in_wait();
        test_random();
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
